// File: rtl/lsu_ctrl.sv
// Purpose: load/store sequencer from the RV32I execute stage onto the dmem req/gnt/rvalid bus.
// Latency: best case 3 cycles from transfer to completion pulse; 1 cycle for misaligned or illegal requests.
// Backpressure: req_ready_o is high only in IDLE; REQ holds the bus outputs until gnt, WAIT until rvalid or timeout.

package rv32i_pkg;
    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } rv32i_base_instr;
endpackage

module lsu_ctrl
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  rv32i_base_instr         opcode_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    resp_valid_o,
    output logic [DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                    misalign_o,
    output logic                    err_o,
    output logic                    dmem_req_o,
    output logic                    dmem_we_o,
    output logic [DATA_WIDTH/8-1:0] dmem_be_o,
    output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
    output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
    input  logic                    dmem_gnt_i,
    input  logic                    dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata_i
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BW-1:0]         be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  misalign_q;
    logic                  err_q;

    logic                  is_legal;
    logic                  is_store;
    logic [1:0]            size;
    logic [1:0]            off;
    logic                  misaligned;
    logic [BW-1:0]         be_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    // Decode the incoming opcode into access size/direction and build lane enables and replicated store data.
    always_comb begin
        is_legal = 1'b1;
        is_store = 1'b0;
        size     = SZ_WORD;
        off      = addr_i[1:0];
        case (opcode_i)
            LB, LBU: size = SZ_BYTE;
            LH, LHU: size = SZ_HALF;
            LW:      size = SZ_WORD;
            SB:      begin size = SZ_BYTE; is_store = 1'b1; end
            SH:      begin size = SZ_HALF; is_store = 1'b1; end
            SW:      begin size = SZ_WORD; is_store = 1'b1; end
            default: is_legal = 1'b0;
        endcase

        misaligned = ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'd0));

        be_d    = {BW{1'b1}};
        wdata_d = wdata_i;
        case (size)
            SZ_BYTE: begin
                be_d    = BW'(1) << off;
                wdata_d = {BW{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_d    = BW'(3) << {off[1], 1'b0};
                wdata_d = {(BW/2){wdata_i[15:0]}};
            end
            default: begin
                be_d    = {BW{1'b1}};
                wdata_d = wdata_i;
            end
        endcase
        // Loads share the lane enables but never drive data onto the bus.
        if (!is_store) begin
            wdata_d = '0;
        end
    end

    // Sequencer: accept in IDLE, hold the request until gnt, then wait for rvalid or time out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            misalign_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (!is_legal) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            misalign_q   <= 1'b0;
                            err_q        <= 1'b1;
                        end else if (misaligned) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            misalign_q   <= 1'b1;
                            err_q        <= 1'b0;
                        end else begin
                            addr_q  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            we_q    <= is_store;
                            state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (dmem_rvalid_i) begin
                        state        <= S_IDLE;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= we_q ? '0 : dmem_rdata_i;
                        misalign_q   <= 1'b0;
                        err_q        <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state        <= S_IDLE;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= '0;
                        misalign_q   <= 1'b0;
                        err_q        <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus outputs are qualified by the request phase so they read as zero whenever nothing is on the bus.
    always_comb begin
        req_ready_o  = (state == S_IDLE);
        dmem_req_o   = (state == S_REQ);
        dmem_we_o    = dmem_req_o & we_q;
        dmem_be_o    = dmem_req_o ? be_q    : '0;
        dmem_addr_o  = dmem_req_o ? addr_q  : '0;
        dmem_wdata_o = dmem_req_o ? wdata_q : '0;
        resp_valid_o = resp_valid_q;
        resp_rdata_o = resp_rdata_q;
        misalign_o   = misalign_q;
        err_o        = err_q;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Purpose: directed scoreboard bench for lsu_ctrl (alignment, lanes, stalls, timeout, reset).
// Latency: responses are checked against the exact cycle they are expected in.
// Backpressure: gnt and rvalid are withheld for scripted numbers of cycles.
module tb_lsu_ctrl;
    import rv32i_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    rv32i_base_instr opcode = ADDI;
    logic [31:0]     addr = '0;
    logic [31:0]     wdata = '0;
    logic            resp_valid;
    logic [31:0]     resp_rdata;
    logic            misalign;
    logic            err;
    logic            dmem_req;
    logic            dmem_we;
    logic [3:0]      dmem_be;
    logic [31:0]     dmem_addr;
    logic [31:0]     dmem_wdata;
    logic            dmem_gnt = 1'b0;
    logic            dmem_rvalid = 1'b0;
    logic [31:0]     dmem_rdata = '0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .opcode_i(opcode), .addr_i(addr), .wdata_i(wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .misalign_o(misalign), .err_o(err),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_be_o(dmem_be),
        .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata),
        .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic [31:0] rd, input logic mis, input logic er, input int at);
        exp_t e;
        e.rdata = rd;
        e.mis   = mis;
        e.err   = er;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    // One full bus transaction: gd cycles without gnt, rd WAIT cycles without rvalid.
    task automatic bus_txn(input rv32i_base_instr op, input logic [31:0] a, input logic [31:0] wd,
                           input int gd, input int rd, input logic [31:0] mem_rdata,
                           input logic [3:0] ebe, input logic [31:0] eaddr, input logic [31:0] ewd,
                           input logic ewe, input logic [31:0] erdata);
        chk("req_ready_idle", req_ready, 1);
        expect_resp(erdata, 1'b0, 1'b0, cyc + 3 + gd + rd);
        req_valid = 1'b1;
        opcode    = op;
        addr      = a;
        wdata     = wd;
        tick();
        req_valid = 1'b0;
        addr      = 32'hFFFF_FFFF;
        wdata     = 32'hA5A5_A5A5;
        for (int i = 0; i <= gd; i++) begin
            chk("dmem_req", dmem_req, 1);
            chk("dmem_addr", dmem_addr, eaddr);
            chk("dmem_be", dmem_be, ebe);
            chk("dmem_wdata", dmem_wdata, ewd);
            chk("dmem_we", dmem_we, ewe);
            chk("req_ready_busy", req_ready, 0);
            dmem_gnt = (i == gd);
            tick();
            dmem_gnt = 1'b0;
        end
        for (int j = 0; j <= rd; j++) begin
            chk("dmem_req_wait", dmem_req, 0);
            if (j == rd) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = mem_rdata;
            end
            tick();
            dmem_rvalid = 1'b0;
            dmem_rdata  = '0;
        end
    endtask

    // Monitor: every completion pulse must match the oldest expected response, including its cycle.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_rdata", resp_rdata, mon_e.rdata);
                chk("resp_misalign", {31'b0, misalign}, {31'b0, mon_e.mis});
                chk("resp_err", {31'b0, err}, {31'b0, mon_e.err});
                chk("resp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset values
        rst = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_be", dmem_be, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Best-case LW
        bus_txn(LW, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 4'hF, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF);
        // Stores: lane replication, store response carries no data
        bus_txn(SB, 32'h203, 32'h12345678, 0, 1, 32'hFFFFFFFF, 4'b1000, 32'h200, 32'h78787878, 1'b1, 32'h0);
        bus_txn(SH, 32'h202, 32'h12345678, 0, 0, 32'hFFFFFFFF, 4'b1100, 32'h200, 32'h56785678, 1'b1, 32'h0);
        bus_txn(SW, 32'h204, 32'hCAFEBABE, 1, 0, 32'h0, 4'hF, 32'h204, 32'hCAFEBABE, 1'b1, 32'h0);
        // Sub-word loads: raw word returned, load wdata is zero
        bus_txn(LBU, 32'h301, 32'h12345678, 0, 2, 32'h11223344, 4'b0010, 32'h300, 32'h0, 1'b0, 32'h11223344);
        bus_txn(LHU, 32'h302, 32'h0, 0, 0, 32'h80008000, 4'b1100, 32'h300, 32'h0, 1'b0, 32'h80008000);
        bus_txn(LB, 32'h300, 32'h0, 0, 0, 32'h000000FF, 4'b0001, 32'h300, 32'h0, 1'b0, 32'h000000FF);
        bus_txn(LH, 32'h300, 32'h0, 0, 0, 32'h0000ABCD, 4'b0011, 32'h300, 32'h0, 1'b0, 32'h0000ABCD);

        // Back-to-back misaligned LH then LW
        t = cyc;
        expect_resp(32'h0, 1'b1, 1'b0, t + 1);
        req_valid = 1'b1;
        opcode    = LH;
        addr      = 32'h101;
        tick();
        chk("mis_req_ready", req_ready, 1);
        chk("mis_dmem_req0", dmem_req, 0);
        expect_resp(32'h0, 1'b1, 1'b0, t + 2);
        opcode = LW;
        addr   = 32'h102;
        tick();
        req_valid = 1'b0;
        chk("mis_req_ready2", req_ready, 1);
        chk("mis_dmem_req1", dmem_req, 0);
        tick();
        chk("mis_hold", misalign, 1);
        chk("mis_no_pulse", resp_valid, 0);
        chk("mis_dmem_req2", dmem_req, 0);

        // gnt withheld 3 cycles
        bus_txn(LW, 32'h300, 32'h0, 3, 0, 32'hCAFEF00D, 4'hF, 32'h300, 32'h0, 1'b0, 32'hCAFEF00D);

        // Timeout after 4 WAIT cycles, then stale rvalid ignored
        t = cyc;
        expect_resp(32'h0, 1'b0, 1'b1, t + 6);
        req_valid = 1'b1;
        opcode    = LW;
        addr      = 32'h400;
        tick();
        req_valid = 1'b0;
        chk("to_dmem_req", dmem_req, 1);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("to_wait_req", dmem_req, 0);
            chk("to_wait_noresp", resp_valid, 0);
            tick();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBAD0BAD0;
        tick();
        chk("to_stale_noresp", resp_valid, 0);
        chk("to_stale_ready", req_ready, 1);
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        bus_txn(LW, 32'h404, 32'h0, 0, 0, 32'h0BADF00D, 4'hF, 32'h404, 32'h0, 1'b0, 32'h0BADF00D);

        // Illegal opcode
        t = cyc;
        expect_resp(32'h0, 1'b0, 1'b1, t + 1);
        req_valid = 1'b1;
        opcode    = ADD;
        addr      = 32'h0;
        tick();
        req_valid = 1'b0;
        chk("ill_dmem_req", dmem_req, 0);
        tick();

        // Reset while in WAIT; rvalid in the next cycle is ignored
        req_valid = 1'b1;
        opcode    = LW;
        addr      = 32'h500;
        tick();
        req_valid = 1'b0;
        dmem_gnt  = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        rst      = 1'b1;
        tick();
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55AA55AA;
        chk("mrst_req_ready", req_ready, 1);
        chk("mrst_dmem_req", dmem_req, 0);
        chk("mrst_resp_valid", resp_valid, 0);
        chk("mrst_dmem_be", dmem_be, 0);
        chk("mrst_dmem_addr", dmem_addr, 0);
        chk("mrst_err", err, 0);
        chk("mrst_rdata", resp_rdata, 0);
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        chk("mrst_no_resp", resp_valid, 0);
        chk("mrst_idle", req_ready, 1);
        bus_txn(LW, 32'h508, 32'h0, 0, 0, 32'h13579BDF, 4'hF, 32'h508, 32'h0, 1'b0, 32'h13579BDF);

        tick();
        tick();
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
